// File: rtl/special_pc_stream_pkg.sv
// Shared types and helpers for the special-PC burst stream.
package special_pc_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Zero-length requests still emit one element; oversize requests saturate.
  function automatic logic [31:0] clamp_len(input logic [31:0] len, input logic [31:0] max_len);
    logic [31:0] res;
    if (len == 32'd0) begin
      res = 32'd1;
    end else if (len > max_len) begin
      res = max_len;
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/special_pc_stream_pc_req_slot.sv
// One-entry request holding register with full flag; a load into a full,
// non-popping slot replaces the entry and raises a one-cycle overwrite pulse.
module pc_req_slot
  import special_pc_stream_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              pop,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] data,
  output logic              full,
  output logic              overwrite
);

  // Slot contents, occupancy and overwrite pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data      <= '0;
      full      <= 1'b0;
      overwrite <= 1'b0;
    end else begin
      overwrite <= load & full & ~pop;
      if (load) begin
        data <= load_data;
        full <= 1'b1;
      end else if (pop) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/special_pc_stream.sv
// Emits a burst of derived PCs (base + k*stride) over valid/ready on each
// rising edge of en, with a one-entry pending slot for retriggers.
module special_pc_stream
  import special_pc_stream_pkg::*;
#(
  parameter int ADDRESS_BITS = 20,
  parameter int STRIDE_BITS  = 8,
  parameter int MAX_LEN      = 8,
  parameter int ALIGN_LSB    = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [ADDRESS_BITS-1:0]        curr_pc,
  input  logic [STRIDE_BITS-1:0]         stride_in,
  input  logic [$clog2(MAX_LEN+1)-1:0]   len_in,
  input  logic                           out_ready,
  output logic                           valid,
  output logic [ADDRESS_BITS-1:0]        out_pc,
  output logic                           done,
  output logic                           busy,
  output logic                           dropped
);

  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int DATA_W = 2 * ADDRESS_BITS + LEN_W;
  localparam logic [ADDRESS_BITS-1:0] ALIGN_MASK =
    ~((ADDRESS_BITS'(1) << ALIGN_LSB) - ADDRESS_BITS'(1));

  state_t                  state_r;
  logic                    en_q_r;
  logic [ADDRESS_BITS-1:0] stride_r;
  logic [LEN_W-1:0]        len_r;
  logic [LEN_W-1:0]        idx_r;

  logic                    trig_s;
  logic [ADDRESS_BITS-1:0] cap_base_s;
  logic [ADDRESS_BITS-1:0] cap_stride_s;
  logic [LEN_W-1:0]        cap_len_s;
  logic                    load_s;
  logic                    pop_s;
  logic                    pend_full_s;
  logic                    pend_full_nxt_s;
  logic [DATA_W-1:0]       pend_data_s;
  logic [ADDRESS_BITS-1:0] pend_base_s;
  logic [ADDRESS_BITS-1:0] pend_stride_s;
  logic [LEN_W-1:0]        pend_len_s;

  // Trigger detection, request capture and pending-slot control.
  always_comb begin
    trig_s          = en & ~en_q_r;
    cap_base_s      = curr_pc & ALIGN_MASK;
    cap_stride_s    = ADDRESS_BITS'($signed(stride_in));
    cap_len_s       = LEN_W'(clamp_len(32'(len_in), 32'(MAX_LEN)));
    load_s          = trig_s & (state_r != ST_IDLE);
    pop_s           = (state_r == ST_DONE) & pend_full_s;
    pend_full_nxt_s = load_s | (pend_full_s & ~pop_s);
    pend_base_s     = pend_data_s[DATA_W-1 -: ADDRESS_BITS];
    pend_stride_s   = pend_data_s[LEN_W +: ADDRESS_BITS];
    pend_len_s      = pend_data_s[LEN_W-1:0];
  end

  pc_req_slot #(
    .DATA_W (DATA_W)
  ) u_pending (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .pop       (pop_s),
    .load_data ({cap_base_s, cap_stride_s, cap_len_s}),
    .data      (pend_data_s),
    .full      (pend_full_s),
    .overwrite (dropped)
  );

  // Burst FSM, element index and out_pc accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      en_q_r   <= 1'b0;
      stride_r <= '0;
      len_r    <= '0;
      idx_r    <= '0;
      valid    <= 1'b0;
      out_pc   <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      en_q_r <= en;
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (trig_s) begin
            state_r  <= ST_EMIT;
            valid    <= 1'b1;
            out_pc   <= cap_base_s + cap_stride_s;
            stride_r <= cap_stride_s;
            len_r    <= cap_len_s;
            idx_r    <= '0;
            busy     <= 1'b1;
          end else begin
            valid <= 1'b0;
            busy  <= pend_full_nxt_s;
          end
        end
        ST_EMIT: begin
          done <= 1'b0;
          busy <= 1'b1;
          if (valid & out_ready) begin
            if (idx_r == len_r - LEN_W'(1)) begin
              state_r <= ST_DONE;
              valid   <= 1'b0;
              done    <= 1'b1;
            end else begin
              idx_r  <= idx_r + LEN_W'(1);
              out_pc <= out_pc + stride_r;
            end
          end
        end
        ST_DONE: begin
          done <= 1'b0;
          // A queued request starts straight after the done pulse.
          if (pend_full_s) begin
            state_r  <= ST_EMIT;
            valid    <= 1'b1;
            out_pc   <= pend_base_s + pend_stride_s;
            stride_r <= pend_stride_s;
            len_r    <= pend_len_s;
            idx_r    <= '0;
            busy     <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            valid   <= 1'b0;
            busy    <= pend_full_nxt_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          valid   <= 1'b0;
          done    <= 1'b0;
          busy    <= pend_full_s;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_special_pc_stream.sv
// Directed self-checking bench for special_pc_stream (default parameters).
module tb_special_pc_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [19:0] curr_pc = 20'h0;
  logic [7:0]  stride_in = 8'h0;
  logic [3:0]  len_in = 4'h0;
  logic        out_ready = 1'b1;
  logic        valid;
  logic [19:0] out_pc;
  logic        done;
  logic        busy;
  logic        dropped;

  int checks = 0;
  int failures = 0;

  special_pc_stream dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .curr_pc   (curr_pc),
    .stride_in (stride_in),
    .len_in    (len_in),
    .out_ready (out_ready),
    .valid     (valid),
    .out_pc    (out_pc),
    .done      (done),
    .busy      (busy),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [19:0] pc, input logic [7:0] s, input logic [3:0] l);
    curr_pc   = pc;
    stride_in = s;
    len_in    = l;
    en        = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      en = ~en;
      checks++;
      if ({valid, done, busy, dropped, out_pc} !== 24'h0) begin
        failures++;
        $display("FAIL reset_hold%0d: v/d/b/dr/pc=%b%b%b%b/%h required all zero", i, valid, done, busy, dropped, out_pc);
      end
    end
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({valid, done, busy, dropped} !== 4'h0) begin
        failures++;
        $display("FAIL reset_release%0d: v/d/b/dr=%b%b%b%b required 0000", i, valid, done, busy, dropped);
      end
    end
  endtask

  task automatic test_basic();
    logic [19:0] exp_pc [3];
    exp_pc = '{20'hb0010, 20'hb0014, 20'hb0018};
    @(negedge clk);
    drive(20'hb000f, 8'd4, 4'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = 1'b0;
      checks++;
      if (valid !== 1'b1 || out_pc !== exp_pc[i] || done !== 1'b0) begin
        failures++;
        $display("FAIL basic_elem%0d: valid=%b out_pc=%h done=%b required 1 %h 0", i, valid, out_pc, done, exp_pc[i]);
      end
    end
    @(negedge clk);
    checks++;
    if ({valid, done, busy} !== 3'b011) begin
      failures++;
      $display("FAIL basic_done: v/d/b=%b%b%b required 011", valid, done, busy);
    end
    @(negedge clk);
    checks++;
    if ({valid, done, busy} !== 3'b000) begin
      failures++;
      $display("FAIL basic_idle: v/d/b=%b%b%b required 000", valid, done, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [19:0] exp_pc [5];
    logic        rdy [5];
    exp_pc = '{20'hb0010, 20'hb0014, 20'hb0014, 20'hb0014, 20'hb0018};
    rdy    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    @(negedge clk);
    drive(20'hb000f, 8'd4, 4'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      en = 1'b0;
      checks++;
      if (valid !== 1'b1 || out_pc !== exp_pc[i] || done !== 1'b0) begin
        failures++;
        $display("FAIL bp_elem%0d: valid=%b out_pc=%h done=%b required 1 %h 0", i, valid, out_pc, done, exp_pc[i]);
      end
      out_ready = rdy[i];
    end
    @(negedge clk);
    checks++;
    if ({valid, done} !== 2'b01) begin
      failures++;
      $display("FAIL bp_done: v/d=%b%b required 01", valid, done);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [19:0] start [2];
    logic [7:0]  str [2];
    logic [19:0] exp_pc [4];
    start  = '{20'hffffc, 20'h00004};
    str    = '{8'h04, 8'hfc};
    exp_pc = '{20'h00000, 20'h00004, 20'h00000, 20'hffffc};
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      drive(start[b], str[b], 4'd2);
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        en = 1'b0;
        checks++;
        if (valid !== 1'b1 || out_pc !== exp_pc[2*b+i]) begin
          failures++;
          $display("FAIL wrap%0d_elem%0d: valid=%b out_pc=%h required 1 %h", b, i, valid, out_pc, exp_pc[2*b+i]);
        end
      end
      @(negedge clk);
      checks++;
      if ({valid, done} !== 2'b01) begin
        failures++;
        $display("FAIL wrap%0d_done: v/d=%b%b required 01", b, valid, done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_hold_en();
    @(negedge clk);
    drive(20'h00100, 8'd8, 4'd1);
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || out_pc !== 20'h00108) begin
      failures++;
      $display("FAIL hold_elem: valid=%b out_pc=%h required 1 00108", valid, out_pc);
    end
    @(negedge clk);
    en = 1'b0;
    checks++;
    if ({valid, done} !== 2'b01) begin
      failures++;
      $display("FAIL hold_done: v/d=%b%b required 01", valid, done);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({valid, done, busy} !== 3'b000) begin
        failures++;
        $display("FAIL hold_single%0d: v/d/b=%b%b%b required 000", i, valid, done, busy);
      end
    end
  endtask

  // Burst of four from 0 with a retrigger at 0x01000; with third_edge a later
  // 0x02000 retrigger replaces it and must raise dropped.
  task automatic test_pending(input bit third_edge);
    logic [19:0] exp_pc [9];
    logic [3:0]  exp_vdrb [9];
    logic [19:0] nb;
    nb = third_edge ? 20'h02000 : 20'h01000;
    exp_pc   = '{20'h4, 20'h8, 20'hc, 20'h10, 20'h0, nb + 20'd4, nb + 20'd8, 20'h0, 20'h0};
    exp_vdrb = '{4'b1001, 4'b1001, 4'b1001, 4'b1001, {2'b01, third_edge, 1'b1},
                 4'b1001, 4'b1001, 4'b0101, 4'b0000};
    @(negedge clk);
    drive(20'h00000, 8'd4, 4'd4);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      en = 1'b0;
      checks++;
      if ({valid, done, dropped, busy} !== exp_vdrb[i] || (exp_vdrb[i][3] && out_pc !== exp_pc[i])) begin
        failures++;
        $display("FAIL pending%0d_cyc%0d: v/d/dr/b=%b%b%b%b out_pc=%h required %b %h",
                 third_edge, i, valid, done, dropped, busy, out_pc, exp_vdrb[i], exp_pc[i]);
      end
      if (i == 1) drive(20'h01000, 8'd4, 4'd2);
      if (i == 3 && third_edge) drive(20'h02000, 8'd4, 4'd2);
    end
  endtask

  task automatic test_clamp();
    logic [3:0]  lens [2];
    int          cnt [2];
    logic [19:0] start [2];
    lens  = '{4'd0, 4'd15};
    cnt   = '{1, 8};
    start = '{20'h00400, 20'h00800};
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      drive(start[b], 8'd1, lens[b]);
      for (int i = 0; i < cnt[b]; i++) begin
        @(negedge clk);
        en = 1'b0;
        checks++;
        if (valid !== 1'b1 || out_pc !== start[b] + 20'(i + 1)) begin
          failures++;
          $display("FAIL clamp%0d_elem%0d: valid=%b out_pc=%h required 1 %h", b, i, valid, out_pc, start[b] + 20'(i + 1));
        end
      end
      @(negedge clk);
      checks++;
      if ({valid, done} !== 2'b01) begin
        failures++;
        $display("FAIL clamp%0d_done: v/d=%b%b required 01", b, valid, done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    drive(20'h03000, 8'd4, 4'd8);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    drive(20'h05000, 8'd4, 4'd2);
    @(negedge clk);
    en = 1'b0;
    checks++;
    if (valid !== 1'b1 || out_pc !== 20'h0300c || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre: valid=%b out_pc=%h busy=%b required 1 0300c 1", valid, out_pc, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({valid, done, busy, dropped, out_pc} !== 24'h0) begin
      failures++;
      $display("FAIL abort_now: v/d/b/dr/pc=%b%b%b%b/%h required all zero", valid, done, busy, dropped, out_pc);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({valid, done, busy, dropped} !== 4'h0) begin
        failures++;
        $display("FAIL abort_after%0d: v/d/b/dr=%b%b%b%b required 0000", i, valid, done, busy, dropped);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_hold_en();
    test_pending(1'b0);
    test_pending(1'b1);
    test_clamp();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
